pa_fpu_fmau_sched: RTL

PA_FPU_FMAU_SCHED -- requirements
Module: pa_fpu_fmau_sched

---
 rtl/pa_fpu_fmau_sched_pkg.sv | 13 +
 rtl/pa_fpu_fmau_sched_if.sv | 59 +++++
 rtl/pa_fpu_wb_buf.sv | 24 ++
 rtl/pa_fpu_fmau_sched.sv | 93 +++++++++
 4 files changed

// File: rtl/pa_fpu_fmau_sched_pkg.sv
// pa_fpu_fmau_sched_pkg: shared FPU constants (EU select, fflags width, canonical NaN) and writeback types
package pa_fpu_fmau_sched_pkg;
    localparam int          FFLAGS_W  = 5;
    localparam logic [2:0]  EU_FMAU   = 3'b010;
    localparam logic [31:0] CANON_NAN = 32'h7fc0_0000;
    typedef logic [FFLAGS_W-1:0] fflags_t;
    typedef enum logic [1:0] {RET_NONE, RET_EX1, RET_EX3, RET_EX4} ret_src_t;
    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        fflags_t     flags;
    } wb_t;
endpackage

// File: rtl/pa_fpu_fmau_sched_if.sv
// pa_fpu_fmau_sched_if: IDU issue, FMAU control/status, RTU control and writeback bundle.
// master = surrounding core (drives issue/status/control), slave = scheduler (drives ctrl/writeback).
interface pa_fpu_fmau_sched_if;
    logic                               idu_fpu_ex1_vld;
    logic [2:0]                         idu_fpu_ex1_eu_sel;
    logic [4:0]                         idu_fpu_ex1_dst_reg;
    logic                               ctrl_fmau_ex1_sel;
    logic                               ctrl_fmau_ex1_sel_gate;
    logic                               ctrl_xx_ex1_stall;
    logic                               ctrl_xx_ex2_stall;
    logic                               ctrl_xx_ex3_stall;
    logic                               ctrl_xx_ex4_stall;
    logic                               ctrl_xx_ex2_cancel;
    logic                               ctrl_xx_ex1_warm_up;
    logic                               ctrl_xx_ex2_warm_up;
    logic                               ctrl_xx_ex3_warm_up;
    logic                               fmau_fpu_ex1_cmplt;
    logic                               fmau_fpu_ex1_denorm_stall;
    pa_fpu_fmau_sched_pkg::fflags_t     fmau_fpu_ex1_fflags;
    logic [31:0]                        fpu_ex1_special_result;
    logic                               fmau_fpu_ex3_result_vld;
    logic [31:0]                        fmau_fpu_ex3_result;
    pa_fpu_fmau_sched_pkg::fflags_t     fmau_fpu_ex3_fflags;
    logic [31:0]                        fmau_fpu_ex4_result;
    pa_fpu_fmau_sched_pkg::fflags_t     fmau_fpu_ex4_fflags;
    logic                               rtu_xx_ex1_cancel;
    logic                               rtu_fpu_flush;
    logic                               rtu_fpu_wb_ready;
    logic                               cp0_fpu_fflags_clr;
    logic                               fpu_rtu_wb_vld;
    logic [31:0]                        fpu_rtu_wb_data;
    logic [4:0]                         fpu_rtu_wb_reg;
    pa_fpu_fmau_sched_pkg::fflags_t     fpu_rtu_wb_fflags;
    pa_fpu_fmau_sched_pkg::fflags_t     fpu_cp0_fflags_acc;

    modport master (
        output idu_fpu_ex1_vld, idu_fpu_ex1_eu_sel, idu_fpu_ex1_dst_reg,
               fmau_fpu_ex1_cmplt, fmau_fpu_ex1_denorm_stall, fmau_fpu_ex1_fflags, fpu_ex1_special_result,
               fmau_fpu_ex3_result_vld, fmau_fpu_ex3_result, fmau_fpu_ex3_fflags,
               fmau_fpu_ex4_result, fmau_fpu_ex4_fflags,
               rtu_xx_ex1_cancel, rtu_fpu_flush, rtu_fpu_wb_ready, cp0_fpu_fflags_clr,
        input  ctrl_fmau_ex1_sel, ctrl_fmau_ex1_sel_gate,
               ctrl_xx_ex1_stall, ctrl_xx_ex2_stall, ctrl_xx_ex3_stall, ctrl_xx_ex4_stall,
               ctrl_xx_ex2_cancel, ctrl_xx_ex1_warm_up, ctrl_xx_ex2_warm_up, ctrl_xx_ex3_warm_up,
               fpu_rtu_wb_vld, fpu_rtu_wb_data, fpu_rtu_wb_reg, fpu_rtu_wb_fflags, fpu_cp0_fflags_acc
    );

    modport slave (
        input  idu_fpu_ex1_vld, idu_fpu_ex1_eu_sel, idu_fpu_ex1_dst_reg,
               fmau_fpu_ex1_cmplt, fmau_fpu_ex1_denorm_stall, fmau_fpu_ex1_fflags, fpu_ex1_special_result,
               fmau_fpu_ex3_result_vld, fmau_fpu_ex3_result, fmau_fpu_ex3_fflags,
               fmau_fpu_ex4_result, fmau_fpu_ex4_fflags,
               rtu_xx_ex1_cancel, rtu_fpu_flush, rtu_fpu_wb_ready, cp0_fpu_fflags_clr,
        output ctrl_fmau_ex1_sel, ctrl_fmau_ex1_sel_gate,
               ctrl_xx_ex1_stall, ctrl_xx_ex2_stall, ctrl_xx_ex3_stall, ctrl_xx_ex4_stall,
               ctrl_xx_ex2_cancel, ctrl_xx_ex1_warm_up, ctrl_xx_ex2_warm_up, ctrl_xx_ex3_warm_up,
               fpu_rtu_wb_vld, fpu_rtu_wb_data, fpu_rtu_wb_reg, fpu_rtu_wb_fflags, fpu_cp0_fflags_acc
    );
endinterface

// File: rtl/pa_fpu_wb_buf.sv
// pa_fpu_wb_buf: 1-entry valid/ready register slice holding one writeback.
// Ports: clk/rst; i_vld/i_wb push side; i_ready consumer accept; o_vld/o_wb registered output.
module pa_fpu_wb_buf
    import pa_fpu_fmau_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_vld,
    input  wb_t  i_wb,
    input  logic i_ready,
    output logic o_vld,
    output wb_t  o_wb
);
    // Payload only changes when a new entry loads, so it is stable while blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vld <= 1'b0;
            o_wb  <= '0;
        end else if (!o_vld || i_ready) begin
            o_vld <= i_vld;
            if (i_vld) o_wb <= i_wb;
        end
    end
endmodule

// File: rtl/pa_fpu_fmau_sched.sv
// pa_fpu_fmau_sched: FMAU ex1-ex4 pipeline scheduler with in-order retirement into a writeback buffer.
// Ports: forever_cpuclk clock; cpurst async active-high reset; bus (slave) carries issue, FMAU
// status, RTU control and the ctrl/writeback/fflags outputs.
module pa_fpu_fmau_sched
    import pa_fpu_fmau_sched_pkg::*;
(
    input  logic                 forever_cpuclk,
    input  logic                 cpurst,
    pa_fpu_fmau_sched_if.slave   bus
);
    logic       r_rdy;
    logic [4:2] r_vld;
    logic [4:0] r_dst2, r_dst3, r_dst4;
    fflags_t    r_acc;
    logic       w_ex1_vld, w_blocked, w_flush;
    logic       w_ret1, w_ret3, w_ret4;
    logic       w_stall1, w_stall2, w_stall3, w_stall4;
    logic       w_adv1, w_adv2, w_adv3;
    logic       w_wb_vld;
    ret_src_t   w_src;
    wb_t        w_wb, w_wb_q;

    // r_rdy holds issue off during reset and the first cycle after release.
    assign w_flush   = bus.rtu_fpu_flush;
    assign w_ex1_vld = bus.idu_fpu_ex1_vld & (bus.idu_fpu_ex1_eu_sel == EU_FMAU) & !bus.rtu_xx_ex1_cancel & r_rdy;
    assign w_blocked = w_wb_vld & !bus.rtu_fpu_wb_ready;
    assign w_ret1    = w_ex1_vld & bus.fmau_fpu_ex1_cmplt;
    assign w_ret3    = r_vld[3] & bus.fmau_fpu_ex3_result_vld;
    assign w_ret4    = r_vld[4];
    // ex4 always wins the writeback port; ex1 completion waits for all older ops to drain.
    assign w_stall4  = r_vld[4] & w_blocked;
    assign w_stall3  = r_vld[3] & ((w_ret3 & (w_blocked | w_ret4)) | w_stall4);
    assign w_stall2  = r_vld[2] & w_stall3;
    assign w_stall1  = w_ex1_vld & ((w_ret1 & (w_blocked | (|r_vld))) | w_stall2 | bus.fmau_fpu_ex1_denorm_stall);
    assign w_adv1    = w_ex1_vld & !w_stall1 & !w_ret1 & !w_flush;
    assign w_adv2    = r_vld[2] & !w_stall2 & !w_flush;
    assign w_adv3    = r_vld[3] & !w_stall3 & !w_ret3 & !w_flush;

    assign w_src = w_flush ? RET_NONE :
                   (w_ret4 & !w_stall4) ? RET_EX4 :
                   (w_ret3 & !w_stall3) ? RET_EX3 :
                   (w_ret1 & !w_stall1) ? RET_EX1 : RET_NONE;
    assign w_wb  = (w_src == RET_EX4) ? wb_t'{data: bus.fmau_fpu_ex4_result, rd: r_dst4, flags: bus.fmau_fpu_ex4_fflags} :
                   (w_src == RET_EX3) ? wb_t'{data: bus.fmau_fpu_ex3_result, rd: r_dst3, flags: bus.fmau_fpu_ex3_fflags} :
                   wb_t'{data: bus.fpu_ex1_special_result, rd: bus.idu_fpu_ex1_dst_reg, flags: bus.fmau_fpu_ex1_fflags};

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_rdy  <= 1'b0;
            r_vld  <= '0;
            r_dst2 <= '0;
            r_dst3 <= '0;
            r_dst4 <= '0;
            r_acc  <= '0;
        end else begin
            r_rdy    <= 1'b1;
            r_vld[2] <= !w_flush & (w_stall2 | w_adv1);
            r_vld[3] <= !w_flush & (w_stall3 | w_adv2);
            r_vld[4] <= !w_flush & (w_stall4 | w_adv3);
            if (w_adv1) r_dst2 <= bus.idu_fpu_ex1_dst_reg;
            if (w_adv2) r_dst3 <= r_dst2;
            if (w_adv3) r_dst4 <= r_dst3;
            if (w_wb_vld && bus.rtu_fpu_wb_ready) r_acc <= bus.cp0_fpu_fflags_clr ? w_wb_q.flags : (r_acc | w_wb_q.flags);
            else if (bus.cp0_fpu_fflags_clr) r_acc <= '0;
        end
    end

    pa_fpu_wb_buf u_wb_buf (
        .clk     (forever_cpuclk),
        .rst     (cpurst),
        .i_vld   (w_src != RET_NONE),
        .i_wb    (w_wb),
        .i_ready (bus.rtu_fpu_wb_ready),
        .o_vld   (w_wb_vld),
        .o_wb    (w_wb_q)
    );

    assign bus.ctrl_fmau_ex1_sel      = w_ex1_vld;
    assign bus.ctrl_fmau_ex1_sel_gate = bus.idu_fpu_ex1_vld & bus.idu_fpu_ex1_eu_sel[1];
    assign bus.ctrl_xx_ex1_stall      = w_stall1;
    assign bus.ctrl_xx_ex2_stall      = w_stall2;
    assign bus.ctrl_xx_ex3_stall      = w_stall3;
    assign bus.ctrl_xx_ex4_stall      = w_stall4;
    assign bus.ctrl_xx_ex2_cancel     = w_flush & r_vld[2];
    assign bus.ctrl_xx_ex1_warm_up    = w_adv1;
    assign bus.ctrl_xx_ex2_warm_up    = w_adv2;
    assign bus.ctrl_xx_ex3_warm_up    = w_adv3;
    assign bus.fpu_rtu_wb_vld         = w_wb_vld;
    assign bus.fpu_rtu_wb_data        = w_wb_q.data;
    assign bus.fpu_rtu_wb_reg         = w_wb_q.rd;
    assign bus.fpu_rtu_wb_fflags      = w_wb_q.flags;
    assign bus.fpu_cp0_fflags_acc     = r_acc;
endmodule
